// File: rtl/feature_marker_writer_if.sv
// Bundles the feature-in handshake, the {mask,addr,data} write port and the frame-done handshake.
// slave is the marker writer's view; master is the upstream/arbiter side.
interface feature_marker_writer_if;
    logic        buf_sel;
    logic [9:0]  feat_x;
    logic [9:0]  feat_y;
    logic        feat_last;
    logic        feat_valid;
    logic        feat_ready;
    logic [53:0] dout;
    logic        valid;
    logic        ready;
    logic        done;
    logic        done_ack;
    logic [15:0] feat_count;

    modport master (
        output buf_sel, feat_x, feat_y, feat_last, feat_valid, ready, done_ack,
        input  feat_ready, dout, valid, done, feat_count
    );

    modport slave (
        input  buf_sel, feat_x, feat_y, feat_last, feat_valid, ready, done_ack,
        output feat_ready, dout, valid, done, feat_count
    );
endinterface

// File: rtl/feature_marker_writer.sv
// Draws a clipped plus-shaped marker into the overlay frame buffer as masked 32-bit word writes.
// Optional marker counter on feat_count is built only when FEATURE_MARKER_COUNT_EN is defined.
//
// state  | meaning
// IDLE   | waiting for a feature (feat_ready=1)
// LOAD   | range check, clip bounds, row base address
// HSEG   | horizontal arm, one write per 4-pixel word
// VSEG   | vertical arm, one write per row, centre row skipped
// FIN    | marker finished, count it, raise done on last feature
// DONE   | holding done until done_ack
module feature_marker_writer #(
    parameter int unsigned WIDTH       = 800,
    parameter int unsigned HEIGHT      = 600,
    parameter int unsigned MARK_R      = 2,
    parameter logic [7:0]  COLOR       = 8'hFF,
    parameter int unsigned FRAME_WORDS = 120000
) (
    input logic                    i_clk_sys,
    input logic                    i_rst_b,
    feature_marker_writer_if.slave bus
);
    localparam logic [17:0] WPR = 18'(WIDTH / 4);
    localparam logic [17:0] FB1 = 18'(FRAME_WORDS);
    localparam logic [9:0]  RAD = 10'(MARK_R);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HSEG, S_VSEG, S_FIN, S_DONE} state_t;

    state_t      r_state, w_next;
    logic [9:0]  r_x, r_y, r_xl, r_xh, r_vrow, r_vcnt;
    logic        r_last, r_buf, r_drawn, r_done, r_feat_ready, r_vnone;
    logic [7:0]  r_hw, r_hcnt;
    logic [17:0] r_row_base, r_vaddr;

    logic        w_in_range, w_valid, w_xfer;
    logic [9:0]  w_xl, w_xh, w_yl, w_yh, w_yoff, w_vrows, w_pix;
    logic [10:0] w_xsum, w_ysum;
    logic [17:0] w_base, w_row_base, w_xw, w_vback, w_addr;
    logic [3:0]  w_hmask, w_mask;

    // Constant-coefficient multiply by words-per-row, reduced to shifts and adds.
    function automatic logic [17:0] f_rows(input logic [9:0] rows);
        logic [17:0] acc;
        acc = '0;
        for (int b = 0; b < 18; b++)
            if (WPR[b]) acc = acc + ({8'd0, rows} << b);
        return acc;
    endfunction

    assign w_in_range = ({1'b0, r_x} < 11'(WIDTH)) && ({1'b0, r_y} < 11'(HEIGHT));
    assign w_xsum     = {1'b0, r_x} + {1'b0, RAD};
    assign w_ysum     = {1'b0, r_y} + {1'b0, RAD};
    assign w_xl       = (r_x >= RAD) ? r_x - RAD : '0;
    assign w_yl       = (r_y >= RAD) ? r_y - RAD : '0;
    assign w_xh       = (w_xsum > 11'(WIDTH - 1))  ? 10'(WIDTH - 1)  : w_xsum[9:0];
    assign w_yh       = (w_ysum > 11'(HEIGHT - 1)) ? 10'(HEIGHT - 1) : w_ysum[9:0];
    assign w_yoff     = r_y - w_yl;
    assign w_vrows    = w_yh - w_yl;
    assign w_base     = r_buf ? FB1 : 18'd0;
    assign w_row_base = w_base + f_rows(r_y);
    assign w_xw       = {10'd0, r_x[9:2]};
    // The arm is at most 3 rows long, so stepping back to the top row needs only these constants.
    assign w_vback    = (w_yoff == 10'd1) ? WPR :
                        (w_yoff == 10'd2) ? (WPR << 1) : (WPR + (WPR << 1));

    always_comb begin
        w_hmask = '0;
        w_pix   = '0;
        for (int i = 0; i < 4; i++) begin
            w_pix      = {r_hw, 2'(i)};
            w_hmask[i] = (w_pix >= r_xl) && (w_pix <= r_xh);
        end
    end

    always_ff @(posedge i_clk_sys or negedge i_rst_b) begin
        if (!i_rst_b) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (bus.feat_valid && r_feat_ready) w_next = S_LOAD;
            S_LOAD: w_next = w_in_range ? S_HSEG : S_FIN;
            S_HSEG: if (w_xfer && r_hcnt == 8'd0) w_next = r_vnone ? S_FIN : S_VSEG;
            S_VSEG: if (w_xfer && r_vcnt == 10'd0) w_next = S_FIN;
            S_FIN:  w_next = r_last ? S_DONE : S_IDLE;
            S_DONE: if (bus.done_ack) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_valid = 1'b0;
        w_mask  = '0;
        w_addr  = '0;
        case (r_state)
            S_HSEG: begin
                w_valid = 1'b1;
                w_mask  = w_hmask;
                w_addr  = r_row_base + {10'd0, r_hw};
            end
            S_VSEG: begin
                w_valid = 1'b1;
                w_mask  = 4'b0001 << r_x[1:0];
                w_addr  = r_vaddr;
            end
            default: ;
        endcase
    end

    assign w_xfer         = w_valid & bus.ready;
    assign bus.valid      = w_valid;
    assign bus.dout       = w_valid ? {w_mask, w_addr, {4{COLOR}}} : '0;
    assign bus.feat_ready = r_feat_ready;
    assign bus.done       = r_done;

    always_ff @(posedge i_clk_sys or negedge i_rst_b) begin
        if (!i_rst_b) begin
            r_x <= '0; r_y <= '0; r_last <= 1'b0; r_buf <= 1'b0;
            r_xl <= '0; r_xh <= '0; r_hw <= '0; r_hcnt <= '0;
            r_row_base <= '0; r_vaddr <= '0; r_vrow <= '0; r_vcnt <= '0;
            r_vnone <= 1'b0; r_drawn <= 1'b0; r_done <= 1'b0; r_feat_ready <= 1'b0;
        end else begin
            r_feat_ready <= (w_next == S_IDLE);
            case (r_state)
                S_IDLE: if (bus.feat_valid && r_feat_ready) begin
                    r_x    <= bus.feat_x;
                    r_y    <= bus.feat_y;
                    r_last <= bus.feat_last;
                    r_buf  <= bus.buf_sel;
                end
                S_LOAD: begin
                    r_drawn    <= w_in_range;
                    r_xl       <= w_xl;
                    r_xh       <= w_xh;
                    r_hw       <= w_xl[9:2];
                    r_hcnt     <= w_xh[9:2] - w_xl[9:2];
                    r_row_base <= w_row_base;
                    r_vnone    <= (w_vrows == 10'd0);
                    r_vcnt     <= w_vrows - 10'd1;
                    // Top row coincides with the centre only when y is on row 0 of the frame.
                    if (w_yl == r_y) begin
                        r_vrow  <= r_y + 10'd1;
                        r_vaddr <= w_row_base + w_xw + WPR;
                    end else begin
                        r_vrow  <= w_yl;
                        r_vaddr <= w_row_base + w_xw - w_vback;
                    end
                end
                S_HSEG: if (w_xfer && r_hcnt != 8'd0) begin
                    r_hw   <= r_hw + 8'd1;
                    r_hcnt <= r_hcnt - 8'd1;
                end
                S_VSEG: if (w_xfer && r_vcnt != 10'd0) begin
                    r_vcnt <= r_vcnt - 10'd1;
                    if (r_vrow + 10'd1 == r_y) begin
                        r_vrow  <= r_vrow + 10'd2;
                        r_vaddr <= r_vaddr + (WPR << 1);
                    end else begin
                        r_vrow  <= r_vrow + 10'd1;
                        r_vaddr <= r_vaddr + WPR;
                    end
                end
                S_FIN:  if (r_last) r_done <= 1'b1;
                S_DONE: if (bus.done_ack) r_done <= 1'b0;
                default: ;
            endcase
        end
    end

`ifdef FEATURE_MARKER_COUNT_EN
    logic [15:0] r_count;

    always_ff @(posedge i_clk_sys or negedge i_rst_b) begin
        if (!i_rst_b)
            r_count <= '0;
        else if (r_state == S_DONE && bus.done_ack)
            r_count <= '0;
        else if (r_state == S_FIN && r_drawn && r_count != 16'hFFFF)
            r_count <= r_count + 16'd1;
    end

    assign bus.feat_count = r_count;
`else
    assign bus.feat_count = '0;
`endif
endmodule

// File: tb/tb_feature_marker_writer.sv
// Self-checking bench for feature_marker_writer: fixed marker table, directed corner sequences,
// and randomized features checked against a pixel-level reference model.
module tb_feature_marker_writer;
    localparam int W   = 800;
    localparam int H   = 600;
    localparam int R   = 2;
    localparam int FW  = 120000;
    localparam int WPR = W / 4;

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    feature_marker_writer_if bus();

    feature_marker_writer dut (
        .i_clk_sys (clk),
        .i_rst_b   (rst_b),
        .bus       (bus)
    );

    int          total = 0;
    int          bad = 0;
    int          exp_count = 0;
    bit          rnd_ready = 1'b0;
    logic [53:0] got[$];
    logic [53:0] exp_q[$];

    typedef struct {
        int          x;
        int          y;
        bit          b;
        bit          last;
        int          n;
        logic [21:0] w [6];
    } vec_t;

    vec_t vt[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    function automatic logic [21:0] mw(input logic [3:0] m, input int a);
        return {m, 18'(a)};
    endfunction

    function automatic logic [15:0] cnt_exp();
`ifdef FEATURE_MARKER_COUNT_EN
        return 16'(exp_count);
`else
        return 16'd0;
`endif
    endfunction

    // Reference: paint the plus pixel by pixel, then group into words in write order.
    function automatic void build_expected(input int x, input int y, input bit b);
        int xl, xh, yl, yh, base;
        logic [3:0] m;
        exp_q.delete();
        if (x >= W || y >= H) return;
        base = b ? FW : 0;
        xl = (x - R < 0) ? 0 : x - R;
        xh = (x + R > W - 1) ? W - 1 : x + R;
        yl = (y - R < 0) ? 0 : y - R;
        yh = (y + R > H - 1) ? H - 1 : y + R;
        for (int w = xl / 4; w <= xh / 4; w++) begin
            m = '0;
            for (int i = 0; i < 4; i++)
                if (4 * w + i >= xl && 4 * w + i <= xh) m[i] = 1'b1;
            exp_q.push_back({m, 18'(base + y * WPR + w), 32'hFFFF_FFFF});
        end
        for (int r = yl; r <= yh; r++) begin
            if (r != y) begin
                m = '0;
                m[x % 4] = 1'b1;
                exp_q.push_back({m, 18'(base + r * WPR + x / 4), 32'hFFFF_FFFF});
            end
        end
    endfunction

    initial begin
        bus.ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    logic [53:0] prev_dout = '0;
    bit          prev_hold = 1'b0;
    always @(negedge clk) begin
        if (prev_hold) begin
            total++;
            if (!(bus.valid === 1'b1 && bus.dout === prev_dout)) begin
                bad++;
                $display("FAIL hold_stable: valid=%b dout=%h want %h", bus.valid, bus.dout, prev_dout);
            end
        end
        if (bus.valid === 1'b1 && bus.ready === 1'b1) got.push_back(bus.dout);
        prev_hold = (bus.valid === 1'b1 && bus.ready === 1'b0 && rst_b === 1'b1);
        prev_dout = bus.dout;
    end

    task automatic send(input int x, input int y, input bit b, input bit last, output bit ok);
        @(posedge clk);
        #1;
        bus.feat_x     = 10'(x);
        bus.feat_y     = 10'(y);
        bus.buf_sel    = b;
        bus.feat_last  = last;
        bus.feat_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (bus.feat_ready === 1'b1) ok = 1'b1;
        end
        @(posedge clk);
        #1;
        bus.feat_valid = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: feat_ready stayed %b want 1", bus.feat_ready);
        end
    endtask

    task automatic run_feature(input int x, input int y, input bit b, input bit last);
        bit ok;
        int n;
        int lim;
        bit drawn;
        got.delete();
        build_expected(x, y, b);
        drawn = (x < W && y < H);
        send(x, y, b, last, ok);
        if (!ok) return;
        if (drawn) begin
            @(negedge clk);
            chk("lat_load_valid", 64'(bus.valid), 64'd0);
            @(negedge clk);
            chk("lat_first_valid", 64'(bus.valid), 64'd1);
        end
        n = 0;
        while (!(bus.feat_ready === 1'b1 || bus.done === 1'b1) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            total++;
            bad++;
            $display("FAIL marker_timeout: feat_ready=%b done=%b want one of them 1", bus.feat_ready, bus.done);
        end
        if (drawn && exp_count < 65535) exp_count++;
        chk("n_writes", 64'(got.size()), 64'(exp_q.size()));
        lim = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < lim; i++) chk("model_write", 64'(got[i]), 64'(exp_q[i]));
        chk("feat_count", 64'(bus.feat_count), 64'(cnt_exp()));
        if (last) begin
            chk("done_set", 64'(bus.done), 64'd1);
            repeat (3) @(negedge clk);
            chk("done_held", 64'(bus.done), 64'd1);
            chk("ready_in_done", 64'(bus.feat_ready), 64'd0);
            @(posedge clk);
            #1;
            bus.done_ack = 1'b1;
            @(posedge clk);
            #1;
            bus.done_ack = 1'b0;
            chk("done_cleared", 64'(bus.done), 64'd0);
            chk("ready_after_ack", 64'(bus.feat_ready), 64'd1);
            exp_count = 0;
            chk("count_after_ack", 64'(bus.feat_count), 64'(cnt_exp()));
        end else begin
            chk("done_idle", 64'(bus.done), 64'd0);
        end
    endtask

    task automatic check_table_entry(input int k);
        chk("tbl_n", 64'(got.size()), 64'(vt[k].n));
        for (int j = 0; j < vt[k].n && j < got.size(); j++) begin
            chk("tbl_mask_addr", 64'(got[j][53:32]), 64'(vt[k].w[j]));
            chk("tbl_data", 64'(got[j][31:0]), 64'hFFFF_FFFF);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int x, y;

        vt[0] = '{x:100, y:50, b:1'b0, last:1'b0, n:6,
                  w:'{mw(4'b1100, 10024), mw(4'b0111, 10025), mw(4'b0001, 9625),
                      mw(4'b0001, 9825), mw(4'b0001, 10225), mw(4'b0001, 10425)}};
        vt[1] = '{x:799, y:599, b:1'b0, last:1'b1, n:3,
                  w:'{mw(4'b1110, 119999), mw(4'b1000, 119599), mw(4'b1000, 119799),
                      22'd0, 22'd0, 22'd0}};
        vt[2] = '{x:800, y:10, b:1'b0, last:1'b1, n:0,
                  w:'{22'd0, 22'd0, 22'd0, 22'd0, 22'd0, 22'd0}};
        vt[3] = '{x:0, y:0, b:1'b1, last:1'b0, n:3,
                  w:'{mw(4'b0111, 120000), mw(4'b0001, 120200), mw(4'b0001, 120400),
                      22'd0, 22'd0, 22'd0}};
        vt[4] = '{x:1, y:300, b:1'b0, last:1'b0, n:5,
                  w:'{mw(4'b1111, 60000), mw(4'b0010, 59600), mw(4'b0010, 59800),
                      mw(4'b0010, 60200), mw(4'b0010, 60400), 22'd0}};

        bus.feat_x = '0; bus.feat_y = '0; bus.buf_sel = 1'b0; bus.feat_last = 1'b0;
        bus.feat_valid = 1'b0; bus.done_ack = 1'b0;

        #12;
        chk("rst_valid", 64'(bus.valid), 64'd0);
        chk("rst_dout", 64'(bus.dout), 64'd0);
        chk("rst_feat_ready", 64'(bus.feat_ready), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_count", 64'(bus.feat_count), 64'd0);
        @(negedge clk);
        rst_b = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_ready", 64'(bus.feat_ready), 64'd1);

        for (int k = 0; k < 5; k++) begin
            run_feature(vt[k].x, vt[k].y, vt[k].b, vt[k].last);
            check_table_entry(k);
        end

        // done_ack with no frame pending must not disturb anything
        @(posedge clk);
        #1;
        bus.done_ack = 1'b1;
        @(posedge clk);
        #1;
        bus.done_ack = 1'b0;
        @(negedge clk);
        chk("stray_ack_done", 64'(bus.done), 64'd0);
        chk("stray_ack_ready", 64'(bus.feat_ready), 64'd1);
        chk("stray_ack_count", 64'(bus.feat_count), 64'(cnt_exp()));

        rnd_ready = 1'b1;
        run_feature(100, 50, 1'b0, 1'b0);
        check_table_entry(0);

        for (int it = 0; it < 40; it++) begin
            rnd_ready = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: begin x = $urandom_range(0, 4);     y = $urandom_range(0, 4);     end
                1: begin x = $urandom_range(795, 805); y = $urandom_range(595, 605); end
                default: begin x = $urandom_range(0, 809); y = $urandom_range(0, 609); end
            endcase
            run_feature(x, y, 1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0));
        end

        // reset in the middle of the second horizontal write
        rnd_ready = 1'b0;
        repeat (2) @(posedge clk);
        got.delete();
        send(100, 50, 1'b0, 1'b0, ok);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #2;
        chk("pre_rst_valid", 64'(bus.valid), 64'd1);
        chk("pre_rst_addr", 64'(bus.dout[49:32]), 64'd10025);
        rst_b = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(bus.valid), 64'd0);
        chk("mid_rst_dout", 64'(bus.dout), 64'd0);
        exp_count = 0;
        chk("mid_rst_count", 64'(bus.feat_count), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_rst_ready", 64'(bus.feat_ready), 64'd1);
        run_feature(100, 50, 1'b0, 1'b0);
        check_table_entry(0);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
